// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer.
//   state_e : sequencer states (HOLD, RELEASE, RUN)
//   cause_e : last-reset cause codes reported on cause_o
//   cnt_width() : register width needed to hold 0..max_count, never below 1
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_KEY = 2'd1,
    CAUSE_SW  = 2'd2
  } cause_e;

  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-facing signal bundle of the reset sequencer.
//   key_i    : raw asynchronous push-button
//   sw_req_i : single-cycle software/watchdog reset request
//   rst_o    : staged active-high resets, bit 0 released first
//   busy_o   : high while any rst_o bit is high
//   cause_o  : cause of the last reset
// slave  = the sequencer side, master = the board/SoC side.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 3
);
  import reset_seq_pkg::*;

  logic               key_i;
  logic               sw_req_i;
  logic [NUM_OUT-1:0] rst_o;
  logic               busy_o;
  cause_e             cause_o;

  modport slave  (input  key_i, sw_req_i, output rst_o, busy_o, cause_o);
  modport master (output key_i, sw_req_i, input  rst_o, busy_o, cause_o);

endinterface

// File: rtl/reset_sequencer_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, polarity correction and a
// stability counter. The accepted level changes only after DEBOUNCE_CYCLES
// consecutive samples that all differ from the current accepted level.
//   clock, reset : system clock, synchronous active-high reset
//   key_i        : raw button level
//   level_o      : debounced level, 1 = pressed
//   press_o      : one-cycle pulse on the edge the level becomes pressed
module key_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw level of a released key; the synchroniser resets to it so that
  // leaving reset never looks like a press.
  localparam logic          KEY_IDLE = ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          sample;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign sample = sync2_q ^ ACTIVE_LOW;  // 1 = pressed

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking assignments here would collapse the synchroniser.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= KEY_IDLE;
      sync2_q <= KEY_IDLE;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = cnt_q;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d = sample;
      press_d = sample;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator. After the last trigger all rst_o bits stay high
// for HOLD_CYCLES, then release one by one in index order STAGE_GAP cycles
// apart. Triggers: reset, a debounced key press, or sw_req_i. The cause of
// the last trigger is kept on cause_o.
//   clock, reset : system clock, synchronous active-high reset (~pll_locked)
//   bus (slave)  : key_i, sw_req_i in; rst_o, busy_o, cause_o out (all registered)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT         = 3,
  parameter int HOLD_CYCLES     = 4096,
  parameter int STAGE_GAP       = 256,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  reset_sequencer_if.slave  bus
);

  localparam int            HW        = cnt_width(HOLD_CYCLES - 1);
  localparam int            GW        = cnt_width(STAGE_GAP - 1);
  localparam int            SW        = cnt_width(NUM_OUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] STG_LAST  = SW'(NUM_OUT - 1);

  state_e             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic               busy_q, busy_d;
  cause_e             cause_q, cause_d;
  logic               key_level, key_press;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (KEY_ACTIVE_LOW)
  ) u_key (
    .clock   (clock),
    .reset   (reset),
    .key_i   (bus.key_i),
    .level_o (key_level),
    .press_o (key_press)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    cause_d = cause_q;

    if (key_press || bus.sw_req_i) begin
      // Any trigger restarts the whole sequence; key wins over software.
      state_d = HOLD;
      hold_d  = '0;
      gap_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      cause_d = key_press ? CAUSE_KEY : CAUSE_SW;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (key_level) begin
            // Countdown only starts once the debounced key is released.
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            stage_d = SW'(1);
            rst_d   = rst_q << 1;  // release bit 0
            state_d = (NUM_OUT == 1) ? RUN : RELEASE;
          end else if (hold_q < HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            // Outputs release low-to-high, so a left shift drops the
            // lowest still-asserted bit.
            rst_d = rst_q << 1;
            if (stage_q >= STG_LAST) begin
              state_d = RUN;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else if (gap_q < GAP_LAST) begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          rst_d = '0;
        end
        default: begin
          state_d = HOLD;
          hold_d  = '0;
          gap_d   = '0;
          stage_d = '0;
          rst_d   = '1;
        end
      endcase
    end
  end

  assign busy_d      = |rst_d;
  assign bus.rst_o   = rst_q;
  assign bus.busy_o  = busy_q;
  assign bus.cause_o = cause_q;

endmodule
